// File: rtl/io_pkg.sv
// Shared FSM state encoding and constants for the processor I/O controller.
package io_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } io_state_t;

   localparam int DEB_CNT_DEFAULT = 50000;

   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for the operator confirm button.
module btn_debounce
   import io_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
   input  logic Clock,
   input  logic Reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (clog2(DEB_CNT) < 1) ? 1 : clog2(DEB_CNT);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Edges are registered alongside the level toggle so they line up with the new level.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= ~level;
            rise  <= ~level;
            fall  <= level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_controller.sv
// CPU I/O block: operator-confirmed input capture with CPU stall, and an
// addressable bank of output registers with per-channel write strobes.
module io_controller
   import io_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SW_W    = 13,
   parameter int NUM_OUT = 2,
   parameter int ADDR_W  = 32,
   parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      InReq,
   input  logic                      OutReq,
   input  logic [ADDR_W-1:0]         Addr,
   input  logic [DATA_W-1:0]         WrData,
   input  logic [SW_W-1:0]           Switches,
   input  logic                      SetBtn,
   output logic [DATA_W-1:0]         RdData,
   output logic                      InValid,
   output logic                      Stall,
   output logic                      WaitLed,
   output logic [NUM_OUT*DATA_W-1:0] OutData,
   output logic [NUM_OUT-1:0]        OutStrobe
);

   localparam int SEL_W = (clog2(NUM_OUT) < 1) ? 1 : clog2(NUM_OUT);
   localparam logic [ADDR_W-1:0] NUM_OUT_A = ADDR_W'(NUM_OUT);

   io_state_t   state, state_n;
   logic [SW_W-1:0]   sw_s1, sw_s2;
   logic [DATA_W-1:0] sw_ext;
   logic        btn_level, btn_rise, btn_fall, press, capture;

   btn_debounce #(.DEB_CNT(DEB_CNT)) u_btn (
      .Clock (Clock),
      .Reset (Reset),
      .raw   (SetBtn),
      .level (btn_level),
      .rise  (btn_rise),
      .fall  (btn_fall)
   );

   assign press   = btn_rise & btn_level;
   assign Stall   = InReq && (state != DONE);
   assign capture = (state == WAIT_PRESS) && InReq && press;

   always_comb begin
      sw_ext = '0;
      sw_ext[SW_W-1:0] = sw_s2;
   end

   // Dropping InReq mid-wait wins over any button edge in the same cycle.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:         if (InReq) state_n = WAIT_PRESS;
         WAIT_PRESS:   if (!InReq) state_n = IDLE; else if (press) state_n = WAIT_RELEASE;
         WAIT_RELEASE: if (!InReq) state_n = IDLE; else if (btn_fall) state_n = DONE;
         DONE:         state_n = IDLE;
         default:      state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state   <= IDLE;
         sw_s1   <= '0;
         sw_s2   <= '0;
         RdData  <= '0;
         InValid <= 1'b0;
         WaitLed <= 1'b0;
      end else begin
         state   <= state_n;
         sw_s1   <= Switches;
         sw_s2   <= sw_s1;
         InValid <= (state_n == DONE);
         WaitLed <= (state_n == WAIT_PRESS) || (state_n == WAIT_RELEASE);
         if (capture) RdData <= sw_ext;
      end
   end

   logic                           wr_en;
   logic [NUM_OUT-1:0]             hit;
   logic [NUM_OUT-1:0][DATA_W-1:0] out_regs;

   assign wr_en = OutReq && !Stall && (Addr < NUM_OUT_A);

   always_comb begin
      hit = '0;
      for (int k = 0; k < NUM_OUT; k++)
         hit[k] = wr_en && (Addr[SEL_W-1:0] == SEL_W'(k));
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         out_regs  <= '0;
         OutStrobe <= '0;
      end else begin
         OutStrobe <= hit;
         for (int k = 0; k < NUM_OUT; k++)
            if (hit[k]) out_regs[k] <= WrData;
      end
   end

   assign OutData = out_regs;

endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller with a short debounce window and four output channels.
module tb_io_controller;

   localparam int DATA_W  = 32;
   localparam int SW_W    = 13;
   localparam int NUM_OUT = 4;
   localparam int ADDR_W  = 32;
   localparam int DEB_CNT = 4;
   localparam int NOPS    = 14;

   logic                      Clock = 1'b0;
   logic                      Reset = 1'b0;
   logic                      InReq = 1'b0;
   logic                      OutReq = 1'b0;
   logic                      SetBtn = 1'b0;
   logic [ADDR_W-1:0]         Addr = '0;
   logic [DATA_W-1:0]         WrData = '0;
   logic [SW_W-1:0]           Switches = '0;
   logic [DATA_W-1:0]         RdData;
   logic                      InValid, Stall, WaitLed;
   logic [NUM_OUT*DATA_W-1:0] OutData;
   logic [NUM_OUT-1:0]        OutStrobe;

   int checks = 0;
   int passes = 0;

   typedef struct {
      int          ch;
      logic [31:0] d;
   } wr_t;

   logic [31:0]               exp_rd[$];
   wr_t                       exp_wr[$];
   logic [NUM_OUT*DATA_W-1:0] model_out = '0;

   bit          op_req [NOPS] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1};
   logic [31:0] op_addr[NOPS] = '{2, 0, 7, 32'h101, 1, 1, 0, 3, 0, 0, 0, 2, 0, 2};
   logic [31:0] op_data[NOPS] = '{32'hDEADBEEF, 0, 32'h77777777, 32'h99999999,
                                  32'hAAAA5555, 32'h12345678, 32'h0BADF00D, 32'hCAFEF00D,
                                  32'hFFFFFFFF, 0, 0, 32'h00000000, 0, 32'h11112222};
   bit          op_in  [NOPS] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};

   io_controller #(
      .DATA_W(DATA_W), .SW_W(SW_W), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W), .DEB_CNT(DEB_CNT)
   ) dut (
      .Clock(Clock), .Reset(Reset), .InReq(InReq), .OutReq(OutReq), .Addr(Addr),
      .WrData(WrData), .Switches(Switches), .SetBtn(SetBtn), .RdData(RdData),
      .InValid(InValid), .Stall(Stall), .WaitLed(WaitLed), .OutData(OutData),
      .OutStrobe(OutStrobe)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (InValid) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         InReq    = ~InReq;
         OutReq   = 1'b1;
         Addr     = ADDR_W'(i);
         WrData   = $urandom;
         Switches = SW_W'($urandom);
         SetBtn   = ~SetBtn;
         tick();
      end
      InReq = 1'b0; OutReq = 1'b0; SetBtn = 1'b0;
      tick();
      checks++; if (RdData !== '0) $display("FAIL reset_rddata: got %h want 0", RdData); else passes++;
      checks++; if (OutData !== '0) $display("FAIL reset_outdata: got %h want 0", OutData); else passes++;
      checks++; if (OutStrobe !== '0) $display("FAIL reset_strobe: got %b want 0", OutStrobe); else passes++;
      checks++; if (InValid !== 1'b0) $display("FAIL reset_invalid: got %b want 0", InValid); else passes++;
      checks++; if (WaitLed !== 1'b0) $display("FAIL reset_waitled: got %b want 0", WaitLed); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", Stall); else passes++;
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_normal();
      int n_valid = 0;
      bit stall_ok = 1'b1;
      bit led_seen = 1'b0;
      logic [31:0] e;
      Switches = 13'h1ABC;
      repeat (3) tick();
      exp_rd.push_back(32'h00001ABC);
      InReq = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         SetBtn = (i < 10);
         if (WaitLed) led_seen = 1'b1;
         if (InValid) begin
            n_valid++;
            checks++; if (Stall !== 1'b0) $display("FAIL normal_done_stall: got %b want 0", Stall); else passes++;
            checks++; if (WaitLed !== 1'b0) $display("FAIL normal_done_led: got %b want 0", WaitLed); else passes++;
            checks++;
            if (exp_rd.size() == 0) $display("FAIL normal_rddata: unexpected InValid, RdData %h", RdData);
            else begin
               e = exp_rd.pop_front();
               if (RdData !== e) $display("FAIL normal_rddata: got %h want %h", RdData, e); else passes++;
            end
            InReq = 1'b0;
         end else if (InReq && Stall !== 1'b1) begin
            stall_ok = 1'b0;
         end
      end
      checks++; if (n_valid !== 1) $display("FAIL normal_invalid_count: got %0d want 1", n_valid); else passes++;
      checks++; if (!stall_ok) $display("FAIL normal_stall_held: Stall dropped early, want 1 until DONE"); else passes++;
      checks++; if (!led_seen) $display("FAIL normal_waitled: got never high want high during wait"); else passes++;
   endtask

   task automatic test_held_button();
      int n_valid = 0;
      bit got;
      logic [31:0] e;
      SetBtn = 1'b1;
      repeat (10) tick();
      Switches = 13'h0555;
      repeat (3) tick();
      InReq = 1'b1;
      repeat (10) begin tick(); if (InValid) n_valid++; end
      SetBtn = 1'b0;
      repeat (10) begin tick(); if (InValid) n_valid++; end
      checks++; if (RdData !== 32'h00001ABC) $display("FAIL held_no_capture: got %h want 00001abc", RdData); else passes++;
      checks++; if (WaitLed !== 1'b1) $display("FAIL held_waitled: got %b want 1", WaitLed); else passes++;
      checks++; if (Stall !== 1'b1) $display("FAIL held_stall: got %b want 1", Stall); else passes++;
      exp_rd.push_back(32'h00000555);
      SetBtn = 1'b1;
      repeat (10) begin tick(); if (InValid) n_valid++; end
      SetBtn = 1'b0;
      wait_valid(30, got);
      checks++; if (n_valid !== 0) $display("FAIL held_early_valid: got %0d pulses want 0", n_valid); else passes++;
      checks++;
      if (!got) $display("FAIL held_repress_timeout: got no InValid want one within 30 cycles");
      else if (exp_rd.size() == 0) $display("FAIL held_repress: scoreboard empty, RdData %h", RdData);
      else begin
         e = exp_rd.pop_front();
         if (RdData !== e) $display("FAIL held_repress: got %h want %h", RdData, e); else passes++;
      end
      InReq = 1'b0;
      tick();
   endtask

   task automatic test_glitch();
      int n_valid = 0;
      Switches = 13'h0777;
      repeat (3) tick();
      InReq = 1'b1;
      for (int g = 0; g < 4; g++) begin
         SetBtn = 1'b1;
         repeat (2) begin tick(); if (InValid) n_valid++; end
         SetBtn = 1'b0;
         repeat (3) begin tick(); if (InValid) n_valid++; end
      end
      checks++; if (RdData !== 32'h00000555) $display("FAIL glitch_rddata: got %h want 00000555", RdData); else passes++;
      checks++; if (WaitLed !== 1'b1) $display("FAIL glitch_waitled: got %b want 1", WaitLed); else passes++;
      checks++; if (n_valid !== 0) $display("FAIL glitch_invalid: got %0d pulses want 0", n_valid); else passes++;
      InReq = 1'b0;
      repeat (2) tick();
      checks++; if (WaitLed !== 1'b0) $display("FAIL glitch_abort_led: got %b want 0", WaitLed); else passes++;
   endtask

   task automatic test_abort_release();
      int n_valid = 0;
      Switches = 13'h0999;
      repeat (3) tick();
      InReq = 1'b1;
      SetBtn = 1'b1;
      repeat (10) begin tick(); if (InValid) n_valid++; end
      checks++; if (WaitLed !== 1'b1) $display("FAIL abort_waitled: got %b want 1", WaitLed); else passes++;
      InReq = 1'b0;
      tick();
      checks++; if (WaitLed !== 1'b0) $display("FAIL abort_led_off: got %b want 0", WaitLed); else passes++;
      checks++; if (Stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", Stall); else passes++;
      SetBtn = 1'b0;
      repeat (12) begin tick(); if (InValid) n_valid++; end
      checks++; if (n_valid !== 0) $display("FAIL abort_invalid: got %0d pulses want 0", n_valid); else passes++;
      checks++; if (RdData !== 32'h00000999) $display("FAIL abort_rddata: got %h want 00000999", RdData); else passes++;
   endtask

   task automatic test_reset_mid_wait();
      InReq = 1'b1;
      repeat (3) tick();
      checks++; if (WaitLed !== 1'b1) $display("FAIL rstwait_led_before: got %b want 1", WaitLed); else passes++;
      Reset = 1'b0;
      tick();
      checks++; if (WaitLed !== 1'b0) $display("FAIL rstwait_led: got %b want 0", WaitLed); else passes++;
      checks++; if (Stall !== 1'b1) $display("FAIL rstwait_stall_high: got %b want 1", Stall); else passes++;
      checks++; if (RdData !== '0) $display("FAIL rstwait_rddata: got %h want 0", RdData); else passes++;
      InReq = 1'b0;
      #1;
      checks++; if (Stall !== 1'b0) $display("FAIL rstwait_stall_low: got %b want 0", Stall); else passes++;
      Reset = 1'b1;
      repeat (3) tick();
      checks++; if (InValid !== 1'b0) $display("FAIL rstwait_invalid: got %b want 0", InValid); else passes++;
   endtask

   task automatic test_output_writes();
      logic [NUM_OUT-1:0] exp_stb;
      wr_t w;
      for (int i = 0; i < NOPS; i++) begin
         OutReq = op_req[i];
         Addr   = op_addr[i];
         WrData = op_data[i];
         InReq  = op_in[i];
         if (op_req[i] && !op_in[i] && op_addr[i] < NUM_OUT)
            exp_wr.push_back('{ch: int'(op_addr[i]), d: op_data[i]});
         tick();
         OutReq  = 1'b0;
         exp_stb = '0;
         if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            exp_stb[w.ch] = 1'b1;
            model_out[w.ch*DATA_W +: DATA_W] = w.d;
         end
         checks++;
         if (OutStrobe !== exp_stb) $display("FAIL wr%0d_strobe: got %b want %b", i, OutStrobe, exp_stb);
         else passes++;
         checks++;
         if (OutData !== model_out) $display("FAIL wr%0d_outdata: got %h want %h", i, OutData, model_out);
         else passes++;
      end
      InReq = 1'b0;
      tick();
      checks++; if (OutStrobe !== '0) $display("FAIL wr_final_strobe: got %b want 0", OutStrobe); else passes++;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_held_button();
      test_glitch();
      test_abort_release();
      test_reset_mid_wait();
      test_output_writes();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Parametrised processor I/O block. Serves the CPU's input instruction with a stall-until-operator-confirms handshake and the output instruction with NUM_OUT addressable output registers.
- Samples an operator switch bank, debounces and synchronises the confirm button, and drives display-facing output registers.
- Sits between the CPU datapath (stall, read data, write data) and the board I/O: switches, button, LEDs and displays.

Parameters:
- DATA_W, 32, CPU data width.
- SW_W, 13, switch-bank width; must be <= DATA_W.
- NUM_OUT, 2, number of output registers/channels; must be >= 1.
- ADDR_W, 32, CPU address width; only the low clog2(NUM_OUT) bits (min 1) plus an upper-bits-zero check are decoded.
- DEB_CNT, 50000, consecutive stable cycles required to accept a button level change; must be >= 1.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- InReq  in  1  CPU executing an input instruction; held until Stall drops.
- OutReq  in  1  CPU executing an output instruction, single-cycle write.
- Addr  in  ADDR_W  output channel select.
- WrData  in  DATA_W  output write data.
- Switches  in  SW_W  asynchronous operator switches.
- SetBtn  in  1  asynchronous confirm button, active-high.
- RdData  out  DATA_W  captured input value, registered.
- InValid  out  1  one-cycle pulse when RdData holds a new value.
- Stall  out  1  CPU halt request, combinational.
- WaitLed  out  1  registered; high while waiting for the operator.
- OutData  out  NUM_OUT*DATA_W  concatenated output registers; channel k is slice [k*DATA_W +: DATA_W].
- OutStrobe  out  NUM_OUT  one-cycle pulse per channel on write.

Behaviour:
- Reset (Reset=0 at a rising edge): FSM to IDLE. RdData, OutData, OutStrobe, InValid, WaitLed, synchroniser flops, debounce counter and debounced level all cleared to 0. Reset mid-wait aborts the wait with no InValid.
- SetBtn path:
  - 2-flop synchroniser, then debouncer.
  - Counter increments while the synchronised value differs from the debounced level; it clears when they match.
  - When the counter reaches DEB_CNT-1 while still differing, the debounced level toggles and the counter clears.
  - rise/fall = single-cycle edges of the debounced level.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: InReq=1 -> WAIT_PRESS.
  - WAIT_PRESS: rise -> capture zero-extended Switches (synchronised by 2 flops) into RdData, go WAIT_RELEASE. A button already held on entry is ignored until released and pressed again (edge-based).
  - WAIT_RELEASE: fall -> DONE.
  - DONE: InValid=1 for exactly this cycle -> IDLE.
  - Abort: InReq=0 in WAIT_PRESS or WAIT_RELEASE -> IDLE. No InValid. RdData keeps whatever it holds (it may already have been overwritten if the press occurred).
- Stall = InReq AND state != DONE. The CPU therefore advances in the DONE cycle. Minimum input latency from the InReq edge is 3 + 2*DEB_CNT cycles.
- WaitLed = 1 in WAIT_PRESS and WAIT_RELEASE, registered from the next-state value.
- Output write:
  - Condition: OutReq=1, Stall=0, Addr < NUM_OUT.
  - Effect: channel Addr is loaded with WrData on that edge, and OutStrobe[Addr]=1 for the following cycle only.
  - Addr >= NUM_OUT: write ignored, no strobe.
  - OutReq while Stall=1 (including simultaneous InReq and OutReq): write dropped, input takes priority.
  - Back-to-back writes to the same channel in consecutive cycles: each write lands, and the strobe stays high for both cycles.
- No combinational path from Switches or SetBtn to any output.

Decomposition:
- Shared package io_pkg holds:
  - the FSM state enum: IDLE=2'd0, WAIT_PRESS=2'd1, WAIT_RELEASE=2'd2, DONE=2'd3;
  - helper function clog2;
  - the default DEB_CNT constant.
- Sub-module btn_debounce (parameter DEB_CNT; ports Clock, Reset, raw, level, rise, fall) covers the synchroniser and debouncer. The top-level io_controller holds the FSM, switch capture and output register file.

Test Plan:
Bench uses DEB_CNT=4, NUM_OUT=4, SW_W=13.
- Reset: hold Reset=0 for 2 cycles with all inputs toggling -> all outputs 0, Stall=0 with InReq=0.
- Normal input: Switches=13'h1ABC, InReq=1, then SetBtn high 10 cycles and low 10 cycles -> Stall stays 1 until the DONE cycle; RdData=32'h00001ABC; InValid pulses exactly once; WaitLed high during the wait.
- Bounce and held button:
  - SetBtn already high when InReq rises -> no capture; after release and re-press, capture proceeds.
  - 2-cycle glitches on SetBtn -> no state change.
- Abort and reset: drop InReq in WAIT_RELEASE -> IDLE, no InValid. Separately, Reset=0 in WAIT_PRESS -> IDLE, Stall follows InReq only.
- Output writes:
  - Addr=2, WrData=32'hDEADBEEF, OutReq=1 -> OutData slice 2 = DEADBEEF, OutStrobe=4'b0100 for one cycle, other slices unchanged.
  - Addr=7 -> no change.
  - OutReq during Stall -> no change.
